hud_digit_sequencer: RTL and testbench
======================================

HUD_DIGIT_SEQUENCER -- requirements
Module: hud_digit_sequencer

Interface
REQ-001 Parameter VAL_W, default 10, is the binary width of the score and gameTime inputs.
REQ-002 Parameter MAX_VAL, default 999, is the clamp value for any displayed number (3 decimal digits).
REQ-003 Clk  in  1  system clock (50 MHz); all state changes on its rising edge.
REQ-004 Reset_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 frame_clk  in  1  frame strobe, already synchronous to Clk; a conversion starts on its rising edge.
REQ-006 score  in  VAL_W  binary score to display.
REQ-007 gameTime  in  VAL_W  binary remaining time to display.
REQ-008 score_d2, score_d1, score_d0  out  4 each  score hundreds, tens and units digit indices (0-9).
REQ-009 time_d2, time_d1, time_d0  out  4 each  gameTime hundreds, tens and units digit indices (0-9).
REQ-010 digits_valid  out  1  one-cycle pulse when a new digit set is committed.
REQ-011 busy  out  1  high while a conversion is in progress (any state other than IDLE).
REQ-012 overrun_cnt  out  8  saturating count of frame_clk edges ignored because busy was high.

Function
REQ-013 The block SHALL replace the per-pixel divide/modulo digit extraction with one serial shift-and-add-3 (double-dabble) conversion per frame.
REQ-014 The block SHALL detect a frame_clk rising edge as frame_clk=1 with a registered previous sample of 0.
REQ-015 The FSM SHALL have exactly four states: IDLE, CONV_S, CONV_T and COMMIT.
REQ-016 IDLE -> CONV_S on a detected edge (capture edge E0); at E0, score and gameTime SHALL be loaded into shadow registers, each clamped to MAX_VAL if larger.
REQ-017 CONV_S SHALL perform one shift/add-3 step per cycle for exactly VAL_W cycles (E1..E10 at default), then go to CONV_T.
REQ-018 CONV_T SHALL convert the gameTime shadow the same way (E11..E20), then go to COMMIT.
REQ-019 COMMIT SHALL, on E21, load all six digit outputs from the BCD results, drive digits_valid=1 for that cycle only, and return to IDLE.
REQ-020 Total latency from capture edge to visible digits SHALL be 2*VAL_W+1 cycles (21 at default).
REQ-021 Digit outputs SHALL change only at COMMIT; they hold their previous values throughout a conversion (no display tearing).
REQ-022 Changes to score or gameTime after E0 SHALL NOT affect the conversion in progress.
REQ-023 A frame_clk rising edge detected while busy=1 SHALL be ignored (not queued) and SHALL increment overrun_cnt, which saturates at 255.
REQ-024 An edge detected in the same cycle as COMMIT SHALL count as an overrun; a new conversion needs an edge seen while in IDLE.
REQ-025 Every digit output SHALL always be in the range 0-9.

Reset
REQ-026 While Reset_n=0 at a clock edge, the following SHALL all be 0: state=IDLE, all digits, digits_valid, busy, overrun_cnt and the shadow registers.
REQ-027 The registered previous frame_clk sample SHALL reset to 1, so a frame_clk held high through reset release starts no conversion.
REQ-028 Reset asserted mid-conversion SHALL abort it, with no digits_valid pulse and outputs at 0.

Verification
REQ-029 Reset; score=345, gameTime=120; pulse frame_clk -> 21 cycles after capture: score digits 3,4,5; time digits 1,2,0; digits_valid high for exactly 1 cycle; busy high for cycles E0+1..E21.
REQ-030 score=1023, gameTime=0 -> score digits 9,9,9 (clamped); time digits 0,0,0.
REQ-031 Convert 345/120, then capture 678/999 and change the inputs to 111/222 at E5 -> digits stay 3,4,5/1,2,0 until E21, then become 6,7,8/9,9,9.
REQ-032 Second frame_clk edge 5 cycles after the first -> no restart; overrun_cnt=1; the commit still occurs at E21.
REQ-033 300 edges, each landing while busy -> overrun_cnt reads 255 and never wraps.
REQ-034 Reset_n=0 at E10 with frame_clk held high through release -> all outputs 0, no digits_valid, busy stays 0 until the next fresh rising edge.

Source files
------------

// File: rtl/hud_digit_sequencer.sv
// rtl/hud_digit_sequencer.sv - serial double-dabble digit sequencer for the HUD score/time readout
//
// Converts the score and gameTime values into three decimal digit indices each, once per
// frame, using one shift/add-3 step per clock instead of per-pixel divide/modulo logic.
//
// Ports:
//   Clk           system clock, all state changes on its rising edge
//   Reset_n       synchronous active-low reset
//   frame_clk     frame strobe (synchronous to Clk); its rising edge starts a conversion
//   score         binary score, clamped to MAX_VAL when captured
//   gameTime      binary remaining time, clamped to MAX_VAL when captured
//   score_d2..d0  score hundreds/tens/units digit indices
//   time_d2..d0   gameTime hundreds/tens/units digit indices
//   digits_valid  one-cycle pulse coinciding with a newly committed digit set
//   busy          high whenever a conversion is in flight (state other than IDLE)
//   overrun_cnt   saturating count of frame_clk edges dropped because busy was high
module hud_digit_sequencer #(
    parameter int VAL_W   = 10,
    parameter int MAX_VAL = 999
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_clk,
    input  logic [VAL_W-1:0] score,
    input  logic [VAL_W-1:0] gameTime,
    output logic [3:0]       score_d2,
    output logic [3:0]       score_d1,
    output logic [3:0]       score_d0,
    output logic [3:0]       time_d2,
    output logic [3:0]       time_d1,
    output logic [3:0]       time_d0,
    output logic             digits_valid,
    output logic             busy,
    output logic [7:0]       overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV_S = 2'd1,
        CONV_T = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int               CNT_W     = $clog2(VAL_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VAL_W - 1);
    localparam logic [VAL_W-1:0] MAX_V     = VAL_W'(MAX_VAL);

    state_t           state;
    state_t           state_nxt;
    logic             frame_prev;
    logic             frame_rise;
    logic [VAL_W-1:0] score_sh;
    logic [VAL_W-1:0] time_sh;
    logic [11:0]      bcd;
    logic [11:0]      bcd_adj;
    logic [11:0]      bcd_step;
    logic [11:0]      score_bcd;
    logic [CNT_W-1:0] step_cnt;
    logic             step_last;
    logic             shift_bit;

    // Add 3 to every BCD nibble that is 5 or more, so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // frame_prev resets high so a strobe held high across reset release is not an edge.
    assign frame_rise = frame_clk & ~frame_prev;
    assign step_last  = (step_cnt == LAST_STEP);

    // One datapath serves both conversions; the state picks which shadow feeds it.
    assign shift_bit  = (state == CONV_T) ? time_sh[VAL_W-1] : score_sh[VAL_W-1];
    assign bcd_adj    = add3(bcd);
    // The top BCD bit is shifted out; clamped inputs never need more than three digits.
    assign bcd_step   = 12'({bcd_adj, shift_bit});

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (frame_rise) state_nxt = CONV_S;
            CONV_S:  if (step_last)  state_nxt = CONV_T;
            CONV_T:  if (step_last)  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_prev   <= 1'b1;
            score_sh     <= '0;
            time_sh      <= '0;
            bcd          <= '0;
            score_bcd    <= '0;
            step_cnt     <= '0;
            score_d2     <= '0;
            score_d1     <= '0;
            score_d0     <= '0;
            time_d2      <= '0;
            time_d1      <= '0;
            time_d0      <= '0;
            digits_valid <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            frame_prev   <= frame_clk;
            digits_valid <= 1'b0;

            // Edges while busy (COMMIT included) are dropped, only counted.
            if (frame_rise && busy && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (frame_rise) begin
                        score_sh <= (score    > MAX_V) ? MAX_V : score;
                        time_sh  <= (gameTime > MAX_V) ? MAX_V : gameTime;
                        bcd      <= '0;
                        step_cnt <= '0;
                    end
                end
                CONV_S: begin
                    score_sh <= score_sh << 1;
                    step_cnt <= step_last ? '0 : step_cnt + CNT_W'(1);
                    if (step_last) begin
                        // Park the score result and clear the accumulator for gameTime.
                        score_bcd <= bcd_step;
                        bcd       <= '0;
                    end else begin
                        bcd <= bcd_step;
                    end
                end
                CONV_T: begin
                    time_sh  <= time_sh << 1;
                    step_cnt <= step_last ? '0 : step_cnt + CNT_W'(1);
                    bcd      <= bcd_step;
                end
                COMMIT: begin
                    // Only place the visible digits change, so a frame never shows a mix.
                    score_d2     <= score_bcd[11:8];
                    score_d1     <= score_bcd[7:4];
                    score_d0     <= score_bcd[3:0];
                    time_d2      <= bcd[11:8];
                    time_d1      <= bcd[7:4];
                    time_d0      <= bcd[3:0];
                    digits_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hud_digit_sequencer.sv
// tb/tb_hud_digit_sequencer.sv - self-checking bench for hud_digit_sequencer
module tb_hud_digit_sequencer;

    localparam int VAL_W       = 10;
    localparam int CONV_CYCLES = 2 * VAL_W + 1;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             frame_clk;
    logic [VAL_W-1:0] score;
    logic [VAL_W-1:0] gameTime;
    logic [3:0]       score_d2, score_d1, score_d0;
    logic [3:0]       time_d2, time_d1, time_d0;
    logic             digits_valid;
    logic             busy;
    logic [7:0]       overrun_cnt;

    logic [11:0]      got_s, got_t;
    logic [11:0]      shown_s, shown_t;
    int               checks = 0;
    int               errors = 0;
    int               exp_ovr = 0;

    assign got_s = {score_d2, score_d1, score_d0};
    assign got_t = {time_d2, time_d1, time_d0};

    always #10 Clk = ~Clk;

    hud_digit_sequencer #(.VAL_W(VAL_W), .MAX_VAL(999)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .score        (score),
        .gameTime     (gameTime),
        .score_d2     (score_d2),
        .score_d1     (score_d1),
        .score_d0     (score_d0),
        .time_d2      (time_d2),
        .time_d1      (time_d1),
        .time_d0      (time_d0),
        .digits_valid (digits_valid),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: clamp to 999 and split into decimal digits with plain arithmetic.
    function automatic logic [11:0] to_digits(input int v);
        int c;
        c = (v > 999) ? 999 : v;
        return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one frame strobe; the edge this tick lands on is the capture edge E0.
    task automatic capture(input int sv, input int tv);
        score     = VAL_W'(sv);
        gameTime  = VAL_W'(tv);
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        score     = VAL_W'($urandom);
        gameTime  = VAL_W'($urandom);
        repeat (3) tick();
        checks++; if (got_s !== 12'h000) begin errors++; $display("FAIL reset_score got %h exp 000", got_s); end
        checks++; if (got_t !== 12'h000) begin errors++; $display("FAIL reset_time got %h exp 000", got_t); end
        checks++; if (digits_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", digits_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun got %0d exp 0", overrun_cnt); end
        Reset_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy); end
        shown_s = 12'h000;
        shown_t = 12'h000;
        exp_ovr = 0;
    endtask

    task automatic test_basic();
        capture(345, 120);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e0 got %b exp 1", busy); end
        for (int k = 1; k < CONV_CYCLES; k++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || digits_valid !== 1'b0 || got_s !== shown_s || got_t !== shown_t) begin
                errors++;
                $display("FAIL basic_hold E%0d got busy=%b valid=%b s=%h t=%h exp busy=1 valid=0 s=%h t=%h",
                         k, busy, digits_valid, got_s, got_t, shown_s, shown_t);
            end
        end
        tick();
        checks++; if (got_s !== to_digits(345)) begin errors++; $display("FAIL basic_score got %h exp %h", got_s, to_digits(345)); end
        checks++; if (got_t !== to_digits(120)) begin errors++; $display("FAIL basic_time got %h exp %h", got_t, to_digits(120)); end
        checks++; if (digits_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_e21 got %b exp 1", digits_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
        shown_s = to_digits(345);
        shown_t = to_digits(120);
        tick();
        checks++; if (digits_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b exp 0", digits_valid); end
        checks++; if (got_s !== shown_s) begin errors++; $display("FAIL basic_score_hold got %h exp %h", got_s, shown_s); end
    endtask

    task automatic test_clamp();
        capture(1023, 0);
        repeat (CONV_CYCLES - 1) tick();
        tick();
        checks++; if (got_s !== 12'h999) begin errors++; $display("FAIL clamp_score got %h exp 999", got_s); end
        checks++; if (got_t !== 12'h000) begin errors++; $display("FAIL clamp_time got %h exp 000", got_t); end
        checks++; if (digits_valid !== 1'b1) begin errors++; $display("FAIL clamp_valid got %b exp 1", digits_valid); end
        shown_s = 12'h999;
        shown_t = 12'h000;
        tick();
    endtask

    // Conversions started the cycle right after each commit, boundaries first.
    task automatic test_back_to_back();
        int tab_s[4] = '{1000, 999, 0, 99};
        int tab_t[4] = '{999, 1000, 1023, 100};
        int sv, tv;
        for (int i = 0; i < 12; i++) begin
            sv = (i < 4) ? tab_s[i] : int'($urandom_range(0, 1023));
            tv = (i < 4) ? tab_t[i] : int'($urandom_range(0, 1023));
            capture(sv, tv);
            checks++;
            if (digits_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_start i=%0d got valid=%b busy=%b exp valid=0 busy=1", i, digits_valid, busy);
            end
            repeat (CONV_CYCLES - 1) tick();
            tick();
            checks++;
            if (got_s !== to_digits(sv) || got_t !== to_digits(tv) || digits_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_result i=%0d in=%0d/%0d got s=%h t=%h valid=%b exp s=%h t=%h valid=1",
                         i, sv, tv, got_s, got_t, digits_valid, to_digits(sv), to_digits(tv));
            end
            shown_s = to_digits(sv);
            shown_t = to_digits(tv);
        end
        tick();
    endtask

    task automatic test_input_change();
        capture(345, 120);
        repeat (CONV_CYCLES) tick();
        checks++;
        if (got_s !== to_digits(345) || got_t !== to_digits(120)) begin
            errors++;
            $display("FAIL change_first got s=%h t=%h exp s=345 t=120", got_s, got_t);
        end
        shown_s = to_digits(345);
        shown_t = to_digits(120);
        capture(678, 999);
        for (int k = 1; k < CONV_CYCLES; k++) begin
            tick();
            if (k == 5) begin
                score    = VAL_W'(111);
                gameTime = VAL_W'(222);
            end
            checks++;
            if (got_s !== shown_s || got_t !== shown_t) begin
                errors++;
                $display("FAIL change_hold E%0d got s=%h t=%h exp s=%h t=%h", k, got_s, got_t, shown_s, shown_t);
            end
        end
        tick();
        checks++;
        if (got_s !== to_digits(678) || got_t !== to_digits(999)) begin
            errors++;
            $display("FAIL change_result got s=%h t=%h exp s=678 t=999", got_s, got_t);
        end
        shown_s = to_digits(678);
        shown_t = to_digits(999);
        tick();
    endtask

    task automatic test_overrun();
        capture(500, 42);
        repeat (4) tick();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
        checks++; if (overrun_cnt !== 8'(exp_ovr)) begin errors++; $display("FAIL overrun_count got %0d exp %0d", overrun_cnt, exp_ovr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy got %b exp 1", busy); end
        repeat (15) begin
            tick();
            checks++; if (digits_valid !== 1'b0) begin errors++; $display("FAIL overrun_early_valid got %b exp 0", digits_valid); end
        end
        tick();
        checks++;
        if (got_s !== to_digits(500) || got_t !== to_digits(42) || digits_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_commit got s=%h t=%h valid=%b exp s=500 t=042 valid=1", got_s, got_t, digits_valid);
        end
        shown_s = to_digits(500);
        shown_t = to_digits(42);
        tick();
    endtask

    // Toggles frame_clk every cycle; a timeline model decides which edges capture and which overrun.
    task automatic test_saturation();
        int   left;
        int   ovr_edges;
        logic fc;
        logic rise;
        logic busy_at;
        left      = 0;
        ovr_edges = 0;
        fc        = 1'b0;
        for (int cyc = 0; cyc < 3000 && ovr_edges < 300; cyc++) begin
            rise      = !fc;
            fc        = !fc;
            frame_clk = fc;
            score     = VAL_W'($urandom);
            gameTime  = VAL_W'($urandom);
            tick();
            busy_at = (left > 0);
            if (busy_at) left--;
            if (rise) begin
                if (busy_at) begin
                    ovr_edges++;
                    if (exp_ovr < 255) exp_ovr++;
                end else begin
                    left = CONV_CYCLES;
                end
            end
            checks++;
            if (overrun_cnt !== 8'(exp_ovr) || busy !== (left > 0)) begin
                errors++;
                $display("FAIL sat_step cyc=%0d got ovr=%0d busy=%b exp ovr=%0d busy=%b",
                         cyc, overrun_cnt, busy, exp_ovr, (left > 0));
            end
        end
        checks++; if (ovr_edges < 300) begin errors++; $display("FAIL sat_edges got %0d exp 300", ovr_edges); end
        frame_clk = 1'b0;
        repeat (CONV_CYCLES + 2) tick();
        checks++; if (overrun_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d exp 255", overrun_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat_idle got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        capture(777, 333);
        repeat (9) tick();
        Reset_n   = 1'b0;
        frame_clk = 1'b1;
        tick();
        checks++;
        if (got_s !== 12'h000 || got_t !== 12'h000 || digits_valid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midreset_outputs got s=%h t=%h valid=%b busy=%b ovr=%0d exp all 0",
                     got_s, got_t, digits_valid, busy, overrun_cnt);
        end
        Reset_n = 1'b1;
        shown_s = 12'h000;
        shown_t = 12'h000;
        exp_ovr = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || digits_valid !== 1'b0 || got_s !== 12'h000) begin
                errors++;
                $display("FAIL midreset_quiet k=%0d got busy=%b valid=%b s=%h exp busy=0 valid=0 s=000",
                         k, busy, digits_valid, got_s);
            end
        end
        frame_clk = 1'b0;
        tick();
        capture(777, 333);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_restart got %b exp 1", busy); end
        repeat (CONV_CYCLES) tick();
        checks++;
        if (got_s !== to_digits(777) || got_t !== to_digits(333) || overrun_cnt !== 8'(exp_ovr)) begin
            errors++;
            $display("FAIL midreset_result got s=%h t=%h ovr=%0d exp s=777 t=333 ovr=%0d",
                     got_s, got_t, overrun_cnt, exp_ovr);
        end
    endtask

    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        score     = '0;
        gameTime  = '0;
        shown_s   = 12'h000;
        shown_t   = 12'h000;
        test_reset();
        test_basic();
        test_clamp();
        test_back_to_back();
        test_input_change();
        test_overrun();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
